elastic_pipeline_reg: RTL and testbench



---
 rtl/elastic_pipeline_reg.sv | 64 ++++++
 tb/tb_elastic_pipeline_reg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipeline_reg.sv
// Elastic valid/ready pipeline register: DEPTH-entry circular buffer whose
// in_ready/out_valid come from registered occupancy only, cutting the ready path.
module elastic_pipeline_reg #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Handshake: a beat transfers on an edge where valid and ready are both high;
  // the source holds valid/data stable until then. flush cancels both sides.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Explicit wrap so non-power-of-two depths index only valid entries.
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage is cleared only by reset; flush leaves stale contents behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_elastic_pipeline_reg.sv
// Bench for elastic_pipeline_reg: three instances (DEPTH 2, 3, 4) checked every
// cycle against a queue-based reference model, directed scenarios then random traffic.
module tb_elastic_pipeline_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] flush;
  logic [2:0] in_valid;
  logic [2:0] out_ready;
  logic [2:0] in_ready_a;
  logic [2:0] out_valid_a;
  logic [7:0] in_data    [3];
  logic [7:0] out_data_a [3];
  logic [2:0] count_a    [3];

  logic [7:0] exp_q [3][$];
  bit         zero_head [3];
  bit         acc [3];
  int         n_pass  = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int D = k + 2;
    localparam int C = $clog2(D + 1);
    logic [C-1:0] cnt;
    elastic_pipeline_reg #(.WIDTH(8), .DEPTH(D)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush[k]),
      .in_data   (in_data[k]),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready_a[k]),
      .out_data  (out_data_a[k]),
      .out_valid (out_valid_a[k]),
      .out_ready (out_ready[k]),
      .count     (cnt)
    );
    assign count_a[k] = 3'(cnt);
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int sz = exp_q[k].size();
      chk("count", k, 32'(count_a[k]), sz);
      chk("in_ready", k, 32'(in_ready_a[k]), 32'(sz != k + 2));
      chk("out_valid", k, 32'(out_valid_a[k]), 32'(sz != 0));
      if (sz != 0)           chk("out_data", k, 32'(out_data_a[k]), 32'(exp_q[k][0]));
      else if (zero_head[k]) chk("out_data_rst", k, 32'(out_data_a[k]), 0);
    end
  endtask

  // One clock: predict transfers from the model's occupancy, take the edge,
  // update the model, then compare every instance away from the edge.
  task automatic cycle();
    bit do_push [3];
    bit do_pop  [3];
    for (int k = 0; k < 3; k++) begin
      do_push[k] = !rst && !flush[k] && in_valid[k] && (exp_q[k].size() != k + 2);
      do_pop[k]  = !rst && !flush[k] && out_ready[k] && (exp_q[k].size() != 0);
      acc[k]     = do_push[k];
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        exp_q[k].delete();
        zero_head[k] = 1'b1;
      end else if (flush[k]) begin
        exp_q[k].delete();
        zero_head[k] = 1'b0;
      end else begin
        if (do_pop[k]) void'(exp_q[k].pop_front());
        if (do_push[k]) begin
          exp_q[k].push_back(in_data[k]);
          zero_head[k] = 1'b0;
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle_all();
    in_valid  = '0;
    out_ready = '0;
    flush     = '0;
  endtask

  task automatic fill(input int k, input logic [7:0] base, input int n);
    out_ready[k] = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid[k] = 1'b1;
      in_data[k]  = base + 8'(i);
      cycle();
    end
    in_valid[k] = 1'b0;
  endtask

  initial begin
    int nxt;
    int pops;
    int maxc;

    // Reset with traffic presented: nothing may be accepted.
    rst = 1'b1;
    flush = '0;
    in_valid = '1;
    out_ready = '1;
    for (int k = 0; k < 3; k++) in_data[k] = 8'h77;
    repeat (2) cycle();
    rst = 1'b0;
    idle_all();
    cycle();

    // Streaming through DEPTH=2 with out_ready held high.
    out_ready[0] = 1'b1;
    pops = 0;
    maxc = 0;
    for (int i = 1; i <= 17; i++) begin
      in_valid[0] = (i <= 16);
      in_data[0]  = 8'(i);
      if (out_valid_a[0] && out_ready[0]) pops++;
      cycle();
      if (int'(count_a[0]) > maxc) maxc = int'(count_a[0]);
    end
    chk("stream_pops", 0, pops, 16);
    chk("stream_maxcnt", 0, maxc, 1);
    idle_all();
    cycle();

    // Backpressure fill then drain on DEPTH=4.
    nxt = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid[2] = 1'b1;
      in_data[2]  = 8'hA0 + 8'(nxt);
      cycle();
      if (acc[2]) nxt++;
    end
    chk("bp_accepted", 2, nxt, 4);
    chk("bp_full_cnt", 2, 32'(count_a[2]), 4);
    out_ready[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid[2] = (nxt < 6);
      in_data[2]  = 8'hA0 + 8'(nxt);
      cycle();
      if (acc[2]) nxt++;
    end
    chk("bp_total", 2, nxt, 6);
    idle_all();
    cycle();

    // Simultaneous push/pop at count=2 on DEPTH=3, exercising pointer wrap.
    fill(1, 8'h30, 2);
    out_ready[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = 8'h40 + 8'(i);
      cycle();
      chk("wrap_cnt", 1, 32'(count_a[1]), 2);
    end
    in_valid[1] = 1'b0;
    repeat (3) cycle();
    idle_all();

    // Flush with traffic on DEPTH=4.
    fill(2, 8'hC0, 3);
    flush[2]     = 1'b1;
    in_valid[2]  = 1'b1;
    in_data[2]   = 8'hEE;
    out_ready[2] = 1'b1;
    cycle();
    flush[2]    = 1'b0;
    in_valid[2] = 1'b0;
    repeat (3) cycle();
    idle_all();

    // Reset together with flush on a full DEPTH=4 buffer.
    fill(2, 8'hD0, 4);
    rst      = 1'b1;
    flush[2] = 1'b1;
    cycle();
    rst      = 1'b0;
    flush[2] = 1'b0;
    cycle();
    in_valid[2]  = 1'b1;
    in_data[2]   = 8'h55;
    out_ready[2] = 1'b1;
    cycle();
    in_valid[2] = 1'b0;
    chk("rof_out", 2, 32'(out_data_a[2]), 32'h55);
    cycle();
    idle_all();

    // Random traffic; upstream holds its beat until accepted.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (acc[k] || !in_valid[k]) begin
          in_valid[k] = ($urandom_range(0, 3) != 0);
          in_data[k]  = 8'($urandom);
        end
        out_ready[k] = ($urandom_range(0, 2) != 0);
        flush[k]     = ($urandom_range(0, 31) == 0);
      end
      acc = '{default: 1'b0};
      cycle();
    end
    idle_all();
    repeat (6) begin
      out_ready = '1;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
